// File: rtl/dbus_bridge_if.sv
`default_nettype none
// ============================================================================
// dbus_bridge_if : LSU-side and memory-side bus signals of dbus_bridge
// Revision: 1.0
// ============================================================================
interface dbus_bridge_if;
  logic        dbus_rd_en;
  logic        dbus_wr_en;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wr_data;
  logic [3:0]  dbus_wr_strobe;
  logic [31:0] dbus_rd_data;
  logic        dbus_wait;
  logic        dbus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;

  // Bridge view: LSU requests and memory responses come in.
  modport slave (
    input  dbus_rd_en, dbus_wr_en, dbus_addr, dbus_wr_data, dbus_wr_strobe,
    input  mem_rdata, mem_ack, mem_err,
    output dbus_rd_data, dbus_wait, dbus_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Environment view: LSU plus memory/peripheral bus.
  modport master (
    output dbus_rd_en, dbus_wr_en, dbus_addr, dbus_wr_data, dbus_wr_strobe,
    output mem_rdata, mem_ack, mem_err,
    input  dbus_rd_data, dbus_wait, dbus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface
`default_nettype wire

// File: rtl/dbus_bridge.sv
`default_nettype none
// ============================================================================
// dbus_bridge : LSU to word-aligned memory bus bridge with timeout/error report
// Revision: 1.0
// ============================================================================
module dbus_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dbus_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        w_req;
  logic [1:0]  w_off;
  logic        w_misal;

  assign w_req   = bus.dbus_rd_en | bus.dbus_wr_en;
  assign w_off   = bus.dbus_addr[1:0];
  assign w_misal = bus.dbus_wr_en &
                   (((bus.dbus_wr_strobe == 4'h3) & w_off[0]) |
                    ((bus.dbus_wr_strobe == 4'hF) & (w_off != 2'd0)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          addr_d  = {bus.dbus_addr[31:2], 2'b00};
          wdata_d = bus.dbus_wr_data << {w_off, 3'b000};
          be_d    = bus.dbus_wr_en ? (bus.dbus_wr_strobe << w_off) : 4'hF;
          we_d    = bus.dbus_wr_en;
          off_d   = w_off;
          cnt_d   = 8'd0;
          if (w_misal) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // A response in the last allowed cycle still counts as completion.
        if (bus.mem_ack | bus.mem_err) begin
          rdata_d = bus.mem_rdata >> {off_q, 3'b000};
          err_d   = bus.mem_err;
          state_d = S_DONE;
        end else if (cnt_q == C_TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      off_q   <= 2'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // err_q is only ever set on entry to DONE, so it is already low elsewhere.
  assign bus.mem_req      = (state_q == S_BUSY);
  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_be       = be_q;
  assign bus.dbus_rd_data = rdata_q;
  assign bus.dbus_err     = err_q;
  assign bus.dbus_wait    = w_req & (state_q != S_DONE) & ~rst_i;

endmodule
`default_nettype wire

// File: tb/tb_dbus_bridge.sv
`default_nettype none
// ============================================================================
// tb_dbus_bridge : directed plus randomized self-checking bench for dbus_bridge
// Revision: 1.0
// ============================================================================
module tb_dbus_bridge;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] exp_rd;

  dbus_bridge_if bus ();

  dbus_bridge #(.TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One LSU access. ack_lat = BUSY cycle (1-based) carrying the response, 0 = never.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int ack_lat, input logic use_err,
                        input logic [31:0] rdata, input logic spurious);
    int          off;
    logic        mis;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          e_busy;
    logic        e_err;
    int          waits;
    int          busy;
    logic        done;

    off   = int'(addr[1:0]);
    mis   = wr && ((strb == 4'h3 && (off % 2) == 1) || (strb == 4'hF && off != 0));
    e_be  = wr ? 4'(strb << off) : 4'hF;
    e_wd  = wdata << (8 * off);
    waits = 0;
    busy  = 0;
    done  = 1'b0;

    bus.dbus_rd_en     = rd;
    bus.dbus_wr_en     = wr;
    bus.dbus_addr      = addr;
    bus.dbus_wr_data   = wdata;
    bus.dbus_wr_strobe = strb;
    bus.mem_ack        = spurious;
    bus.mem_err        = 1'b0;
    bus.mem_rdata      = $urandom;
    #1;
    check("idle_req", bus.mem_req, 1'b0);
    check("idle_err", bus.dbus_err, 1'b0);
    if (bus.dbus_wait) waits++;

    for (int c = 0; c < 200 && !done; c++) begin
      next_cycle();
      bus.mem_ack   = 1'b0;
      bus.mem_err   = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        busy++;
        check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
        check("mem_be", bus.mem_be, e_be);
        check("mem_we", bus.mem_we, wr);
        if (wr) check("mem_wdata", bus.mem_wdata, e_wd);
        if (busy == ack_lat) begin
          if (use_err) bus.mem_err = 1'b1;
          else         bus.mem_ack = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
      #1;
      if (bus.dbus_wait) begin
        waits++;
        check("err_busy", bus.dbus_err, 1'b0);
      end else begin
        done = 1'b1;
      end
    end
    check("completed", done, 1'b1);

    if (mis) begin
      e_busy = 0;
      e_err  = 1'b1;
    end else if (ack_lat >= 1 && ack_lat <= TMO) begin
      e_busy = ack_lat;
      e_err  = use_err;
      exp_rd = rdata >> (8 * off);
    end else begin
      e_busy = TMO;
      e_err  = 1'b1;
    end

    check("busy_cycles", busy, e_busy);
    check("wait_cycles", waits, e_busy + 1);
    check("done_err", bus.dbus_err, e_err);
    check("rd_data", bus.dbus_rd_data, exp_rd);
    check("done_req", bus.mem_req, 1'b0);

    next_cycle();
    bus.dbus_rd_en = 1'b0;
    bus.dbus_wr_en = 1'b0;
    #1;
    check("post_err", bus.dbus_err, 1'b0);
    check("post_wait", bus.dbus_wait, 1'b0);
    check("post_req", bus.mem_req, 1'b0);
  endtask

  initial begin
    logic [3:0] strobes [3];
    logic       r;
    logic       w;
    strobes[0] = 4'h1;
    strobes[1] = 4'h3;
    strobes[2] = 4'hF;

    // Reset with a request pending: wait must stay low while rst is high.
    rst                = 1'b1;
    bus.dbus_rd_en     = 1'b1;
    bus.dbus_wr_en     = 1'b0;
    bus.dbus_addr      = 32'h0;
    bus.dbus_wr_data   = 32'h0;
    bus.dbus_wr_strobe = 4'h1;
    bus.mem_rdata      = 32'h0;
    bus.mem_ack        = 1'b0;
    bus.mem_err        = 1'b0;
    repeat (3) next_cycle();
    #1;
    check("rst_wait", bus.dbus_wait, 1'b0);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_be", bus.mem_be, 4'h0);
    check("rst_rd", bus.dbus_rd_data, 32'h0);
    check("rst_err", bus.dbus_err, 1'b0);
    exp_rd         = 32'h0;
    bus.dbus_rd_en = 1'b0;
    rst            = 1'b0;
    next_cycle();

    // Directed: SB, read with latency 3, misaligned SW, SH, timeouts, mem_err.
    access(1'b0, 1'b1, 32'h0000_1003, 32'h0000_00A5, 4'h1, 1, 1'b0, 32'h1111_2222, 1'b0);
    access(1'b1, 1'b0, 32'h0000_2002, 32'h0, 4'h1, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
    check("read_dead", bus.dbus_rd_data, 32'h0000_DEAD);
    access(1'b0, 1'b1, 32'h0000_3001, 32'h1234_5678, 4'hF, 1, 1'b0, 32'h5555_5555, 1'b0);
    access(1'b0, 1'b1, 32'h0000_3002, 32'h0000_BEEF, 4'h3, 1, 1'b0, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h1, 0, 1'b0, 32'hAAAA_AAAA, 1'b0);
    access(1'b1, 1'b0, 32'h0000_5001, 32'h0, 4'h1, TMO, 1'b0, 32'hCAFE_F00D, 1'b0);
    access(1'b1, 1'b1, 32'h0000_6002, 32'h0000_0077, 4'h1, 2, 1'b1, 32'h0BAD_0BAD, 1'b0);
    access(1'b1, 1'b0, 32'h0000_7003, 32'h0, 4'h1, 2, 1'b0, 32'h89AB_CDEF, 1'b0);

    // Reset in BUSY cycle 2: no DONE, outputs return to reset values.
    bus.dbus_rd_en = 1'b1;
    bus.dbus_addr  = 32'h0000_4001;
    #1;
    check("rb_wait0", bus.dbus_wait, 1'b1);
    next_cycle();
    check("rb_req1", bus.mem_req, 1'b1);
    next_cycle();
    check("rb_req2", bus.mem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rb_wait_rst", bus.dbus_wait, 1'b0);
    next_cycle();
    check("rb_req", bus.mem_req, 1'b0);
    check("rb_err", bus.dbus_err, 1'b0);
    check("rb_rd", bus.dbus_rd_data, 32'h0);
    check("rb_be", bus.mem_be, 4'h0);
    check("rb_addr", bus.mem_addr, 32'h0);
    exp_rd         = 32'h0;
    rst            = 1'b0;
    bus.dbus_rd_en = 1'b0;
    next_cycle();
    check("rb_idle_req", bus.mem_req, 1'b0);

    // Randomized accesses against the per-access model in the task.
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      access(r, w, $urandom, $urandom, strobes[$urandom_range(0, 2)],
             int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
             $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dbus_bridge.md
# dbus_bridge

Sequential data-bus bridge between the combinational LSU and the data-memory/peripheral bus. It converts the LSU's low-aligned byte-lane stores into word-aligned, lane-shifted memory writes, and right-aligns read data so the LSU always finds the addressed byte or half-word at bit 0. It sequences each access through a small FSM, drives `dbus_wait` until the access completes, and reports misaligned stores, bus errors and bus timeouts on `dbus_err`.

## Interface
- `TIMEOUT`, default 15: maximum number of BUSY cycles without `mem_ack` before the access is aborted with an error. Legal range 1-255.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `dbus_rd_en`  in  1  LSU read request
- `dbus_wr_en`  in  1  LSU write request
- `dbus_addr`  in  32  byte address
- `dbus_wr_data`  in  32  store data, low-aligned
- `dbus_wr_strobe`  in  4  store lanes, low-aligned: 4'h1, 4'h3 or 4'hF
- `dbus_rd_data`  out  32  read data, right-shifted by byte offset (registered)
- `dbus_wait`  out  1  access not yet complete (combinational)
- `dbus_err`  out  1  access aborted (registered)
- `mem_req`  out  1  memory request, held until ack or timeout
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word address, `{dbus_addr[31:2], 2'b00}`
- `mem_wdata`  out  32  lane-shifted store data
- `mem_be`  out  4  lane-shifted byte enables
- `mem_rdata`  in  32  memory read word
- `mem_ack`  in  1  access complete, `mem_rdata` valid
- `mem_err`  in  1  access failed; counts as completion

## Operation
- Byte offset `off = dbus_addr[1:0]`. `mem_wdata = dbus_wr_data << 8*off` and `mem_be = dbus_wr_strobe << off`, both truncated to their width. For reads, `mem_be = 4'hF` and `mem_we = 0`.
- Store misalignment:
  - strobe 4'h3 is misaligned when `off[0] = 1`;
  - strobe 4'hF is misaligned when `off != 0`;
  - strobe 4'h1 is never misaligned.
  - Reads are never flagged as misaligned.
- Request = `dbus_rd_en | dbus_wr_en`. If both are set, the access is a write.
- FSM states:
  - IDLE: on a request, latch address, data, enables and `we`.
    - Aligned request: go to BUSY with the counter cleared.
    - Misaligned store: go to DONE with the error flag set and no `mem_req`.
  - BUSY: `mem_req` = 1 and the counter increments each cycle.
    - On `mem_ack | mem_err`: capture `mem_rdata >> 8*off` into `dbus_rd_data`, set the error flag to `mem_err`, go to DONE.
    - When the counter reaches `TIMEOUT` with no ack: set the error flag, leave `dbus_rd_data` unchanged, go to DONE.
  - DONE: `mem_req` = 0, `dbus_wait` = 0, `dbus_err` = error flag. Go to IDLE next cycle unconditionally.
- `dbus_wait = request & (state != DONE) & !rst`.
- The LSU holds its request stable through the DONE cycle. The bridge never restarts on the request seen in DONE.
- `dbus_err` is 0 in every state except DONE.

## Timing
- Reset values: state IDLE, counter 0, `mem_req`/`mem_we` 0, `mem_addr`/`mem_wdata` 0, `mem_be` 0, `dbus_rd_data` 0, `dbus_err` 0, `dbus_wait` 0.
- Reset in BUSY: `mem_req` drops on the next edge and no completion is reported.
- Minimum aligned access, with request in cycle 0 and ack in cycle 1:
  - cycle 0: IDLE, `dbus_wait` = 1
  - cycle 1: BUSY, `mem_req` = 1
  - cycle 2: DONE, result valid, `dbus_wait` = 0
  - Total 2 wait cycles.
- Ack in cycle k of BUSY: DONE in cycle k+1.
- Misaligned store: IDLE in cycle 0, DONE with error in cycle 1. `mem_req` is never asserted.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, followed by DONE with error.
- `mem_addr`, `mem_wdata`, `mem_be` and `mem_we` are stable while `mem_req` = 1.
- An ack arriving in the same cycle the counter reaches `TIMEOUT` is a success (ack wins).
- `mem_ack`/`mem_err` outside BUSY are ignored.

## Test plan
- SB to 0x1003 with data 0x000000A5, strobe 4'h1 -> `mem_addr` 0x1000, `mem_be` 4'h8, `mem_wdata` 0xA5000000. `dbus_wait` high for 2 cycles, `dbus_err` 0.
- Read of 0x2002 with `mem_rdata` 0xDEADBEEF and ack after 3 BUSY cycles -> `dbus_rd_data` 0x0000DEAD in DONE, `mem_be` 4'hF, 4 wait cycles.
- SW to 0x3001 -> DONE in cycle 1 with `dbus_err` 1 and `mem_req` never asserted. SH to 0x3002 -> aligned, `mem_be` 4'hC.
- `TIMEOUT` = 4 and no ack -> `mem_req` high exactly 4 cycles, then DONE with `dbus_err` 1. Repeat with ack in cycle 4 -> `dbus_err` 0.
- `mem_err` without ack in BUSY cycle 2 -> DONE with `dbus_err` 1, then back to IDLE. The next request starts a normal access.
- `rst` asserted in BUSY cycle 2 -> `mem_req` 0 on the next edge, all outputs at reset values, no DONE cycle.
